vga_draw_sched: RTL and testbench

VGA_DRAW_SCHED -- requirements
Module: vga_draw_sched

---
 rtl/vga_draw_sched.sv | 176 +++++++++++++++++
 tb/tb_vga_draw_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_sched.sv
// Frame draw scheduler: arbitrates one framebuffer plot port among three
// drawing requesters (erase, wall, bird) once per display frame, and holds
// the picture frozen after a collision until the player restarts.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   frame_tick            one-cycle pulse per display frame
//   collision, go         collision level, restart key level
//   req, done             per-requester request level / completion pulse
//   x_in, y_in, colour_in packed per-requester coordinates and colour
//   plot_in               per-requester pixel write strobe
//   grant                 registered one-hot owner of the plot port
//   x, y, colour, plot    plot port muxed from the granted requester
//   busy, frozen          in a draw phase / in game-over freeze
//   frame_count           completed frames (wraps)
//   overrun, timeout_err  sticky error flags
module vga_draw_sched #(
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        collision,
  input  logic        go,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [23:0] x_in,
  input  logic [20:0] y_in,
  input  logic [8:0]  colour_in,
  input  logic [2:0]  plot_in,
  output logic [2:0]  grant,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        frozen,
  output logic [7:0]  frame_count,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned WD_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERASE  = 3'd1,
    WALL   = 3'd2,
    BIRD   = 3'd3,
    FROZEN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              pend_q, pend_d;
  logic              latch_q, latch_d;
  logic              ovr_d, tmo_d, fc_inc;
  logic              in_phase, owner_done, phase_end;

  // First requested phase among the bits left set in mask, in draw order.
  function automatic state_t pick_phase(input logic [2:0] mask);
    if (mask[0])      return ERASE;
    else if (mask[1]) return WALL;
    else if (mask[2]) return BIRD;
    else              return IDLE;
  endfunction

  function automatic logic [2:0] grant_of(input state_t s);
    case (s)
      ERASE:   return 3'b001;
      WALL:    return 3'b010;
      BIRD:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign in_phase   = (state_q == ERASE) || (state_q == WALL) || (state_q == BIRD);
  // grant always mirrors state_q, so it selects the owner's done bit.
  assign owner_done = |(done & grant);
  assign phase_end  = owner_done || (wd_q == (TIMEOUT - 16'd1));

  // Next-state and flag update logic.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q + WD_W'(1);
    pend_d  = pend_q;
    latch_d = latch_q | collision;
    ovr_d   = overrun;
    tmo_d   = timeout_err;
    fc_inc  = 1'b0;

    if (in_phase && frame_tick) begin
      if (pend_q) ovr_d = 1'b1;
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (latch_q) begin
          state_d = FROZEN;
        end else if (frame_tick || pend_q) begin
          pend_d  = 1'b0;
          state_d = pick_phase(req);
          if (req == 3'b000) fc_inc = 1'b1;
        end
      end
      ERASE, WALL, BIRD: begin
        if (phase_end) begin
          wd_d = '0;
          if (!owner_done) tmo_d = 1'b1;
          // Skip phases not requested at the decision point.
          case (state_q)
            ERASE:   state_d = pick_phase(req & 3'b110);
            WALL:    state_d = pick_phase(req & 3'b100);
            default: state_d = IDLE;
          endcase
          if (state_d == IDLE) fc_inc = 1'b1;
        end
      end
      FROZEN: begin
        wd_d   = '0;
        pend_d = 1'b0;
        if (go && !collision) begin
          latch_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      pend_q      <= 1'b0;
      latch_q     <= 1'b0;
      grant       <= 3'b000;
      busy        <= 1'b0;
      frozen      <= 1'b0;
      frame_count <= 8'd0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      pend_q      <= pend_d;
      latch_q     <= latch_d;
      grant       <= grant_of(state_d);
      busy        <= (state_d == ERASE) || (state_d == WALL) || (state_d == BIRD);
      frozen      <= (state_d == FROZEN);
      frame_count <= frame_count + 8'(fc_inc);
      overrun     <= ovr_d;
      timeout_err <= tmo_d;
    end
  end

  // Plot port mux; grant is one-hot or zero.
  always_comb begin
    x      = '0;
    y      = '0;
    colour = '0;
    if (grant[0]) begin
      x = x_in[7:0];   y = y_in[6:0];   colour = colour_in[2:0];
    end else if (grant[1]) begin
      x = x_in[15:8];  y = y_in[13:7];  colour = colour_in[5:3];
    end else if (grant[2]) begin
      x = x_in[23:16]; y = y_in[20:14]; colour = colour_in[8:6];
    end
  end

  assign plot = |(plot_in & grant);

endmodule

// File: tb/tb_vga_draw_sched.sv
module tb_vga_draw_sched;

  localparam int TIMEOUT_A = 20000;

  logic        clk = 1'b0;
  logic        resetn, frame_tick, collision, go;
  logic [2:0]  req, done, plot_in;
  logic [23:0] x_in;
  logic [20:0] y_in;
  logic [8:0]  colour_in;

  logic [2:0]  grant_a, colour_a, grant_b, colour_b;
  logic [7:0]  x_a, fc_a, x_b, fc_b;
  logic [6:0]  y_a, y_b;
  logic        plot_a, busy_a, frozen_a, ovr_a, tmo_a;
  logic        plot_b, busy_b, frozen_b, ovr_b, tmo_b;

  vga_draw_sched dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .collision(collision), .go(go),
    .req(req), .done(done), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
    .grant(grant_a), .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a), .busy(busy_a),
    .frozen(frozen_a), .frame_count(fc_a), .overrun(ovr_a), .timeout_err(tmo_a)
  );

  vga_draw_sched #(.TIMEOUT(16'd8)) dut_t (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .collision(collision), .go(go),
    .req(req), .done(done), .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
    .grant(grant_b), .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b), .busy(busy_b),
    .frozen(frozen_b), .frame_count(fc_b), .overrun(ovr_b), .timeout_err(tmo_b)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model of dut: owner index of the plot port (-1 = none).
  int m_owner, m_wd, m_fc;
  bit m_pend, m_latch, m_frz, m_ovr, m_terr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_req(input int from, input logic [2:0] r);
    for (int i = from; i < 3; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_wd = 0; m_fc = 0;
    m_pend = 0; m_latch = 0; m_frz = 0; m_ovr = 0; m_terr = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic m_step();
    bit nl;
    nl = m_latch | collision;
    if (m_owner >= 0) begin
      bit d;
      d = done[m_owner];
      if (frame_tick) begin
        if (m_pend) m_ovr = 1;
        m_pend = 1;
      end
      if (d || m_wd == TIMEOUT_A - 1) begin
        if (!d) m_terr = 1;
        m_owner = first_req(m_owner + 1, req);
        m_wd = 0;
        if (m_owner < 0) m_fc = (m_fc + 1) % 256;
      end else begin
        m_wd++;
      end
    end else if (m_frz) begin
      m_pend = 0;
      if (go && !collision) begin
        nl = 0;
        m_frz = 0;
      end
    end else if (m_latch) begin
      m_frz = 1;
    end else if (frame_tick || m_pend) begin
      m_pend = 0;
      m_owner = first_req(0, req);
      if (m_owner < 0) m_fc = (m_fc + 1) % 256;
    end
    m_latch = nl;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] eg;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       ep;
    eg = 3'b000; ex = '0; ey = '0; ec = '0; ep = 1'b0;
    if (m_owner >= 0) begin
      eg = 3'(1 << m_owner);
      ex = x_in[8*m_owner +: 8];
      ey = y_in[7*m_owner +: 7];
      ec = colour_in[3*m_owner +: 3];
      ep = plot_in[m_owner];
    end
    chk({tag, ".grant"}, 32'(grant_a), 32'(eg));
    chk({tag, ".x"}, 32'(x_a), 32'(ex));
    chk({tag, ".y"}, 32'(y_a), 32'(ey));
    chk({tag, ".colour"}, 32'(colour_a), 32'(ec));
    chk({tag, ".plot"}, 32'(plot_a), 32'(ep));
    chk({tag, ".busy"}, 32'(busy_a), 32'(m_owner >= 0));
    chk({tag, ".frozen"}, 32'(frozen_a), 32'(m_frz));
    chk({tag, ".frame_count"}, 32'(fc_a), 32'(m_fc));
    chk({tag, ".overrun"}, 32'(ovr_a), 32'(m_ovr));
    chk({tag, ".timeout_err"}, 32'(tmo_a), 32'(m_terr));
  endtask

  // One clock: fresh pixel data, model step, edge, check.
  task automatic step(input string tag);
    x_in = 24'($urandom); y_in = 21'($urandom);
    colour_in = 9'($urandom); plot_in = 3'($urandom);
    m_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic quiet();
    frame_tick = 0; done = 0; collision = 0; go = 0;
  endtask

  task automatic do_reset();
    quiet();
    resetn = 0;
    m_reset();
    @(posedge clk);
    #1;
    resetn = 1;
    check_all("reset");
  endtask

  // Hold the current owner for n granted cycles, pulsing its done on the last.
  task automatic run_phase(input string tag, input logic [2:0] own, input int n);
    for (int c = 1; c <= n; c++) begin
      done = (c == n) ? own : 3'b000;
      step(tag);
    end
    done = 0;
  endtask

  initial begin
    int cnt;
    quiet();
    req = 0; x_in = 0; y_in = 0; colour_in = 0; plot_in = 0;
    resetn = 0;
    m_reset();
    #12;
    check_all("por");
    chk("por.grant_b", 32'(grant_b), 32'(0));
    resetn = 1;
    step("idle");

    // Full frame: all three phases in order.
    req = 3'b111; frame_tick = 1; step("f111.start"); frame_tick = 0;
    chk("f111.erase", 32'(grant_a), 32'(3'b001));
    run_phase("f111.erase", 3'b001, 5);
    chk("f111.wall", 32'(grant_a), 32'(3'b010));
    run_phase("f111.wall", 3'b010, 10);
    chk("f111.bird", 32'(grant_a), 32'(3'b100));
    run_phase("f111.bird", 3'b100, 3);
    chk("f111.busy_end", 32'(busy_a), 32'(0));
    chk("f111.fc", 32'(fc_a), 32'(1));

    // Skip WALL; stray done[1] during ERASE ignored.
    req = 3'b101; frame_tick = 1; step("f101.start"); frame_tick = 0;
    done = 3'b010; step("f101.stray"); step("f101.stray");
    chk("f101.still_erase", 32'(grant_a), 32'(3'b001));
    run_phase("f101.erase", 3'b001, 1);
    chk("f101.direct_bird", 32'(grant_a), 32'(3'b100));
    run_phase("f101.bird", 3'b100, 2);

    // Watchdog on the short-timeout instance.
    do_reset();
    req = 3'b010; frame_tick = 1; step("to.start"); frame_tick = 0;
    cnt = (grant_b == 3'b010) ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      step("to.wait");
      if (grant_b == 3'b010) cnt++;
    end
    chk("to.cycles", 32'(cnt), 32'(8));
    chk("to.grant", 32'(grant_b), 32'(0));
    chk("to.err", 32'(tmo_b), 32'(1));
    chk("to.fc", 32'(fc_b), 32'(1));
    run_phase("to.finish_a", 3'b010, 1);

    // Pending and overrun.
    do_reset();
    req = 3'b001; frame_tick = 1; step("ov.start"); frame_tick = 0;
    step("ov.erase");
    frame_tick = 1; step("ov.tick1"); frame_tick = 0;
    chk("ov.no_overrun", 32'(ovr_a), 32'(0));
    frame_tick = 1; step("ov.tick2"); frame_tick = 0;
    chk("ov.overrun", 32'(ovr_a), 32'(1));
    done = 3'b001; step("ov.done"); done = 0;
    chk("ov.idle", 32'(grant_a), 32'(0));
    step("ov.restart");
    chk("ov.next_frame", 32'(grant_a), 32'(3'b001));
    run_phase("ov.erase2", 3'b001, 2);

    // Collision during WALL, then freeze and restart.
    do_reset();
    req = 3'b111; frame_tick = 1; step("col.start"); frame_tick = 0;
    run_phase("col.erase", 3'b001, 2);
    collision = 1; step("col.hit"); collision = 0;
    run_phase("col.wall", 3'b010, 2);
    chk("col.bird", 32'(grant_a), 32'(3'b100));
    run_phase("col.bird", 3'b100, 2);
    step("col.to_frozen");
    chk("col.frozen", 32'(frozen_a), 32'(1));
    frame_tick = 1; step("col.tick_ignored"); frame_tick = 0;
    chk("col.still_frozen", 32'(grant_a), 32'(0));
    go = 1; collision = 1; step("col.both"); collision = 0;
    chk("col.both_frozen", 32'(frozen_a), 32'(1));
    step("col.go"); go = 0;
    chk("col.unfrozen", 32'(frozen_a), 32'(0));
    step("col.idle");

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      req        = 3'($urandom);
      frame_tick = ($urandom_range(0, 7) == 0);
      done       = 3'($urandom) & 3'($urandom);
      collision  = ($urandom_range(0, 63) == 0);
      go         = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    // frame_count wrap and asynchronous reset mid-BIRD.
    do_reset();
    req = 3'b000; frame_tick = 1;
    for (int i = 0; i < 255; i++) step("wrap.fill");
    frame_tick = 0;
    chk("wrap.255", 32'(fc_a), 32'(255));
    req = 3'b100; frame_tick = 1; step("wrap.start"); frame_tick = 0;
    run_phase("wrap.bird", 3'b100, 1);
    chk("wrap.zero", 32'(fc_a), 32'(0));
    frame_tick = 1; step("rst.start"); frame_tick = 0;
    step("rst.bird");
    resetn = 0;
    m_reset();
    #2;
    chk("rst.async_grant", 32'(grant_a), 32'(0));
    chk("rst.async_plot", 32'(plot_a), 32'(0));
    chk("rst.async_busy", 32'(busy_a), 32'(0));
    @(posedge clk);
    #1;
    resetn = 1;
    step("rst.no_tick");
    step("rst.no_tick");
    chk("rst.stays_idle", 32'(grant_a), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
